wb_pipe_slice: RTL
==================

WB_PIPE_SLICE -- requirements
Module: wb_pipe_slice

Interface
REQ-001 Parameter ADR_WIDTH, default 16, address bus width.
REQ-002 Parameter DAT_WIDTH, default 16, read/write data width.
REQ-003 Parameter SEL_WIDTH, default 2, data select width.
REQ-004 clk_i  in  1  clock; all logic on rising edge.
REQ-005 async_rst_i  in  1  asynchronous, active-high reset.
REQ-006 sync_rst_i  in  1  synchronous, active-high reset.
REQ-007 itr_cyc_i  in  1  initiator bus cycle indicator.
REQ-008 itr_stb_i  in  1  initiator access request.
REQ-009 itr_we_i  in  1  initiator write enable.
REQ-010 itr_sel_i  in  SEL_WIDTH  initiator data selects.
REQ-011 itr_adr_i  in  ADR_WIDTH  initiator address.
REQ-012 itr_dat_i  in  DAT_WIDTH  initiator write data.
REQ-013 itr_ack_o  out  1  acknowledge to initiator.
REQ-014 itr_err_o  out  1  error to initiator.
REQ-015 itr_rty_o  out  1  retry to initiator.
REQ-016 itr_stall_o  out  1  stall to initiator.
REQ-017 itr_dat_o  out  DAT_WIDTH  read data to initiator.
REQ-018 tgt_cyc_o  out  1  bus cycle indicator to target.
REQ-019 tgt_stb_o  out  1  access request to target.
REQ-020 tgt_we_o  out  1  write enable to target.
REQ-021 tgt_sel_o  out  SEL_WIDTH  data selects to target.
REQ-022 tgt_adr_o  out  ADR_WIDTH  address to target.
REQ-023 tgt_dat_o  out  DAT_WIDTH  write data to target.
REQ-024 tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i  in  1 each  target responses.
REQ-025 tgt_dat_i  in  DAT_WIDTH  target read data.

Function
REQ-026 Block SHALL be a fully registered pipelined-Wishbone slice: no combinational path from any input to any output.
REQ-027 Accept = itr_cyc_i & itr_stb_i & ~itr_stall_o; drain = tgt_stb_o & ~tgt_stall_i.
REQ-028 Request buffer SHALL be a main register M (drives tgt_we/sel/adr/dat_o) plus a skid register S; tgt_stb_o = M valid; itr_stall_o = S valid.
REQ-029 States: EMPTY (M=0,S=0), ONE (M=1,S=0), FULL (M=1,S=1).
REQ-030 EMPTY: accept -> ONE, M loads request.
REQ-031 ONE: accept & ~drain -> FULL (S loads); accept & drain -> ONE (M reloads); ~accept & drain -> EMPTY; else hold.
REQ-032 FULL: drain -> ONE, S moves to M; else hold; no accept possible.
REQ-033 Request latency: accepted request appears on tgt_stb_o the next cycle; sustained throughput one access per cycle when tgt_stall_i low.
REQ-034 tgt_cyc_o SHALL be itr_cyc_i delayed by one cycle.
REQ-035 itr_ack/err/rty_o SHALL be tgt_ack/err/rty_i registered, gated by tgt_cyc_o & itr_cyc_i; latency one cycle.
REQ-036 itr_dat_o SHALL load tgt_dat_i only when tgt_ack_i & tgt_cyc_o; otherwise hold.
REQ-037 Abort: itr_cyc_i low SHALL flush M and S to EMPTY next cycle and suppress responses; tgt_cyc_o falls the same edge.
REQ-038 Write data/sel SHALL pass unmodified; read data SHALL be returned in target order.

Reset
REQ-039 async_rst_i or sync_rst_i SHALL force EMPTY and all outputs to 0, including itr_dat_o and tgt_adr/dat/sel_o.
REQ-040 Reset mid-transfer SHALL discard buffered requests and pending responses; first accept possible the cycle after reset release.

Structure
REQ-041 State encoding (EMPTY/ONE/FULL) SHALL reside in shared package wbxbc_pkg.
REQ-042 The M/S request buffer SHALL be sub-module wb_pipe_slice_skid; the response register stays in the top level.

Verification
REQ-043 Single write adr=0x1234 dat=0xBEEF, stall low -> tgt_stb_o high one cycle later with same adr/dat; ack returns itr_ack_o one cycle after tgt_ack_i.
REQ-044 Four back-to-back reads, tgt_stall_i low -> four tgt_stb_o pulses consecutive, itr_stall_o never high, itr_dat_o in order.
REQ-045 tgt_stall_i high 3 cycles during a burst -> itr_stall_o high after second accept, no request lost or duplicated, order preserved.
REQ-046 itr_cyc_i dropped with FULL buffer -> next cycle tgt_cyc_o=0, tgt_stb_o=0, itr_stall_o=0, later tgt_ack_i ignored.
REQ-047 async_rst_i pulsed mid-burst -> all outputs 0 immediately; new write accepted the cycle after release.
REQ-048 tgt_err_i on second of two reads -> itr_ack_o then itr_err_o on consecutive cycles, itr_dat_o holds first read value.

Source files
------------

// File: rtl/wbxbc_pkg.sv
// ---------------------------------------------------------------------------
// wbxbc_pkg
// Shared definitions for the Wishbone crossbar family of blocks.
// Holds the occupancy encoding of the two-entry request buffer used by
// the pipeline slices, plus small helpers that decode it.
// ---------------------------------------------------------------------------
package wbxbc_pkg;

    // Occupancy of the main/skid request buffer.
    // EMPTY: nothing held. ONE: main register valid. FULL: main and skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Main register is valid whenever anything is buffered.
    function automatic logic skid_m_valid(input skid_state_e state);
        return state != EMPTY;
    endfunction

    // Skid register only holds a request when the buffer is full.
    function automatic logic skid_s_valid(input skid_state_e state);
        return state == FULL;
    endfunction

endpackage

// File: rtl/wb_pipe_slice_skid.sv
// ---------------------------------------------------------------------------
// wb_pipe_slice_skid
// Two-entry request buffer (main register M plus skid register S) for the
// pipelined Wishbone slice. M drives the target-side request; S absorbs the
// one request that may be accepted in the cycle the target starts stalling.
//
// Ports
//   clk_i, async_rst_i, sync_rst_i : clock, async and sync active-high resets
//   flush_i     : drop everything buffered (initiator abandoned its cycle)
//   push_i      : initiator presents a request (cyc & stb)
//   we_i/sel_i/adr_i/dat_i : request payload
//   pop_stall_i : target stall; M leaves when valid and this is low
//   m_valid_o   : M holds a request (target strobe)
//   s_valid_o   : S holds a request (stall back to initiator)
//   m_we_o/m_sel_o/m_adr_o/m_dat_o : payload of M
// ---------------------------------------------------------------------------
module wb_pipe_slice_skid
    import wbxbc_pkg::*;
#(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int SEL_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 async_rst_i,
    input  logic                 sync_rst_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic                 we_i,
    input  logic [SEL_WIDTH-1:0] sel_i,
    input  logic [ADR_WIDTH-1:0] adr_i,
    input  logic [DAT_WIDTH-1:0] dat_i,
    input  logic                 pop_stall_i,
    output logic                 m_valid_o,
    output logic                 s_valid_o,
    output logic                 m_we_o,
    output logic [SEL_WIDTH-1:0] m_sel_o,
    output logic [ADR_WIDTH-1:0] m_adr_o,
    output logic [DAT_WIDTH-1:0] m_dat_o
);

    localparam int REQ_WIDTH = 1 + SEL_WIDTH + ADR_WIDTH + DAT_WIDTH;

    skid_state_e          state_q, state_d;
    logic [REQ_WIDTH-1:0] m_q, m_d;
    logic [REQ_WIDTH-1:0] s_q, s_d;
    logic [REQ_WIDTH-1:0] req_in;
    logic                 accept;
    logic                 drain;

    assign req_in = {we_i, sel_i, adr_i, dat_i};

    // The initiator sees S-valid as its stall, so nothing can be accepted
    // while full. Draining only depends on M being valid.
    assign accept = push_i & ~skid_s_valid(state_q);
    assign drain  = skid_m_valid(state_q) & ~pop_stall_i;

    // Next occupancy and register loads. Payload registers hold by default;
    // a flush only clears occupancy, stale payload is simply not strobed.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        m_d     = req_in;
                    end
                end
                ONE: begin
                    if (accept && !drain) begin
                        state_d = FULL;
                        s_d     = req_in;
                    end else if (accept && drain) begin
                        m_d     = req_in;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_d = ONE;
                        m_d     = s_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Either reset empties the buffer and zeroes the payload so the
    // target-side request outputs read as 0.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else if (sync_rst_i) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    assign m_valid_o = skid_m_valid(state_q);
    assign s_valid_o = skid_s_valid(state_q);
    assign {m_we_o, m_sel_o, m_adr_o, m_dat_o} = m_q;

endmodule

// File: rtl/wb_pipe_slice.sv
// ---------------------------------------------------------------------------
// wb_pipe_slice
// Fully registered pipelined-Wishbone pipeline slice. Requests pass through
// a two-entry main/skid buffer; responses and the target cycle signal are
// each registered once. Every output comes straight from a flop.
//
// Ports
//   clk_i, async_rst_i, sync_rst_i : clock, async and sync active-high resets
//   itr_*_i / itr_*_o : initiator side (cyc, stb, we, sel, adr, dat in;
//                       ack, err, rty, stall, dat out)
//   tgt_*_o / tgt_*_i : target side (cyc, stb, we, sel, adr, dat out;
//                       ack, err, rty, stall, dat in)
// ---------------------------------------------------------------------------
module wb_pipe_slice
    import wbxbc_pkg::*;
#(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int SEL_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 async_rst_i,
    input  logic                 sync_rst_i,
    input  logic                 itr_cyc_i,
    input  logic                 itr_stb_i,
    input  logic                 itr_we_i,
    input  logic [SEL_WIDTH-1:0] itr_sel_i,
    input  logic [ADR_WIDTH-1:0] itr_adr_i,
    input  logic [DAT_WIDTH-1:0] itr_dat_i,
    output logic                 itr_ack_o,
    output logic                 itr_err_o,
    output logic                 itr_rty_o,
    output logic                 itr_stall_o,
    output logic [DAT_WIDTH-1:0] itr_dat_o,
    output logic                 tgt_cyc_o,
    output logic                 tgt_stb_o,
    output logic                 tgt_we_o,
    output logic [SEL_WIDTH-1:0] tgt_sel_o,
    output logic [ADR_WIDTH-1:0] tgt_adr_o,
    output logic [DAT_WIDTH-1:0] tgt_dat_o,
    input  logic                 tgt_ack_i,
    input  logic                 tgt_err_i,
    input  logic                 tgt_rty_i,
    input  logic                 tgt_stall_i,
    input  logic [DAT_WIDTH-1:0] tgt_dat_i
);

    logic                 tgt_cyc_q, tgt_cyc_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 rty_q, rty_d;
    logic [DAT_WIDTH-1:0] rdat_q, rdat_d;

    // Dropping cyc flushes the buffer; the request buffer handles its own
    // accept/drain handshake.
    wb_pipe_slice_skid #(
        .ADR_WIDTH (ADR_WIDTH),
        .DAT_WIDTH (DAT_WIDTH),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .async_rst_i (async_rst_i),
        .sync_rst_i  (sync_rst_i),
        .flush_i     (~itr_cyc_i),
        .push_i      (itr_cyc_i & itr_stb_i),
        .we_i        (itr_we_i),
        .sel_i       (itr_sel_i),
        .adr_i       (itr_adr_i),
        .dat_i       (itr_dat_i),
        .pop_stall_i (tgt_stall_i),
        .m_valid_o   (tgt_stb_o),
        .s_valid_o   (itr_stall_o),
        .m_we_o      (tgt_we_o),
        .m_sel_o     (tgt_sel_o),
        .m_adr_o     (tgt_adr_o),
        .m_dat_o     (tgt_dat_o)
    );

    // Responses only pass while both the target-side cycle (as seen by the
    // target) and the live initiator cycle are up, so an abort swallows any
    // late termination. Read data is captured on ack only, keeping the last
    // good read visible through err/rty.
    always_comb begin
        tgt_cyc_d = itr_cyc_i;
        ack_d     = tgt_ack_i & tgt_cyc_q & itr_cyc_i;
        err_d     = tgt_err_i & tgt_cyc_q & itr_cyc_i;
        rty_d     = tgt_rty_i & tgt_cyc_q & itr_cyc_i;
        rdat_d    = rdat_q;
        if (tgt_ack_i && tgt_cyc_q) begin
            rdat_d = tgt_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            tgt_cyc_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rty_q     <= 1'b0;
            rdat_q    <= '0;
        end else if (sync_rst_i) begin
            tgt_cyc_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rty_q     <= 1'b0;
            rdat_q    <= '0;
        end else begin
            tgt_cyc_q <= tgt_cyc_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rty_q     <= rty_d;
            rdat_q    <= rdat_d;
        end
    end

    assign tgt_cyc_o = tgt_cyc_q;
    assign itr_ack_o = ack_q;
    assign itr_err_o = err_q;
    assign itr_rty_o = rty_q;
    assign itr_dat_o = rdat_q;

endmodule
